fpu_normalize_round: RTL and testbench

- Consumes the unnormalized sign-magnitude sum or difference from the FPU integer adder stage: WIDTH+1-bit extended magnitude, sign, and the biased exponent of the larger operand.
- Normalizes iteratively, rounds to nearest-even, and packs an IEEE-754 binary64 result with status flags.
- Sits between the adder and the FPU result register; valid/ready handshake on both sides, one operation in flight.

---
 rtl/fpu_normalize_round.sv | 230 +++++++++++++++++++++++
 tb/tb_fpu_normalize_round.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fpu_normalize_round.sv
// Normalizes an unnormalized sign-magnitude adder result, rounds to nearest-even and packs binary64.
// Define FPU_NORM_LZC_EN to normalize in one cycle (leading-zero count + barrel shift) instead of bit-serially.
module fpu_normalize_round #(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52,
    parameter int WIDTH  = 56
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH:0]        in_mant,
    input  logic                  in_sign,
    input  logic [EXP_W-1:0]      in_exp,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+FRAC_W:0] out_result,
    output logic                  out_overflow,
    output logic                  out_underflow,
    output logic                  out_inexact
);

    localparam logic [EXP_W:0]        EXP_ZERO  = {(EXP_W+1){1'b0}};
    localparam logic [EXP_W:0]        EXP_ONE   = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W:0]        EXP_MAX   = {1'b0, {EXP_W{1'b1}}};
    localparam logic [WIDTH:0]        MANT_ZERO = {(WIDTH+1){1'b0}};
    localparam logic [FRAC_W-1:0]     FRAC_ZERO = {FRAC_W{1'b0}};
    localparam logic [EXP_W+FRAC_W:0] RES_ZERO  = {(EXP_W+FRAC_W+1){1'b0}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CAPT  = 3'd1,
        S_NORM  = 3'd2,
        S_ROUND = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [WIDTH:0]          mant_q, mant_d;
    logic [EXP_W:0]          exp_q, exp_d;
    logic                    sign_q, sign_d;
    logic                    out_valid_q, out_valid_d;
    logic [EXP_W+FRAC_W:0]   result_q, result_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;
    logic                    inx_q, inx_d;

    logic                    rnd_g_s, rnd_r_s, rnd_st_s, rnd_up_s;
    logic [FRAC_W+1:0]       rnd_sum_s;
    logic [EXP_W:0]          rnd_exp_s;
    logic [FRAC_W-1:0]       rnd_frac_s;
    logic                    rnd_inx_s, rnd_ovf_s, rnd_unf_s;
    logic [EXP_W+FRAC_W:0]   rnd_result_s;

`ifdef FPU_NORM_LZC_EN
    localparam int LZ_W = $clog2(WIDTH + 1);

    function automatic logic [LZ_W-1:0] lzc_f(input logic [WIDTH-1:0] v);
        logic [LZ_W-1:0] cnt;
        cnt = LZ_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            cnt = v[i] ? LZ_W'(WIDTH - 1 - i) : cnt;
        end
        return cnt;
    endfunction

    logic [LZ_W-1:0] lzc_s;
    logic [EXP_W:0]  lzc_ext_s, exp_m1_s, shamt_s, norm_exp_s;
    logic [WIDTH:0]  norm_mant_s;

    // one-shot normalize; the shift is clamped so a denormal stops at exponent 1 then drops to 0
    always_comb begin
        lzc_s     = lzc_f(mant_q[WIDTH-1:0]);
        lzc_ext_s = {{(EXP_W+1-LZ_W){1'b0}}, lzc_s};
        exp_m1_s  = exp_q - EXP_ONE;
        if (lzc_ext_s <= exp_m1_s) begin
            shamt_s = lzc_ext_s;
        end else begin
            shamt_s = exp_m1_s;
        end
        norm_mant_s = mant_q << shamt_s;
        if (!norm_mant_s[WIDTH-1]) begin
            norm_exp_s = EXP_ZERO;
        end else begin
            norm_exp_s = exp_q - shamt_s;
        end
    end
`endif

    // round-to-nearest-even, exponent fix-up and packing of the normalized value
    always_comb begin
        rnd_g_s   = mant_q[2];
        rnd_r_s   = mant_q[1];
        rnd_st_s  = mant_q[0];
        rnd_up_s  = rnd_g_s & (rnd_r_s | rnd_st_s | mant_q[3]);
        rnd_sum_s = {1'b0, mant_q[WIDTH-1:3]} + {{(FRAC_W+1){1'b0}}, rnd_up_s};
        rnd_frac_s = rnd_sum_s[FRAC_W-1:0];
        if (rnd_sum_s[FRAC_W+1]) begin
            rnd_frac_s = FRAC_ZERO;
            rnd_exp_s  = exp_q + EXP_ONE;
        end else if ((exp_q == EXP_ZERO) && rnd_sum_s[FRAC_W]) begin
            rnd_exp_s = EXP_ONE;
        end else begin
            rnd_exp_s = exp_q;
        end
        rnd_inx_s = rnd_g_s | rnd_r_s | rnd_st_s;
        if (rnd_exp_s >= EXP_MAX) begin
            rnd_result_s = {sign_q, {EXP_W{1'b1}}, FRAC_ZERO};
            rnd_ovf_s    = 1'b1;
            rnd_inx_s    = 1'b1;
        end else begin
            rnd_result_s = {sign_q, rnd_exp_s[EXP_W-1:0], rnd_frac_s};
            rnd_ovf_s    = 1'b0;
        end
        rnd_unf_s = (rnd_exp_s == EXP_ZERO) & rnd_inx_s;
    end

    // next-state and datapath update for the capture / normalize / round / output sequence
    always_comb begin
        state_d     = state_q;
        mant_d      = mant_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        inx_d       = inx_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_CAPT;
                    mant_d  = in_mant;
                    exp_d   = (in_exp == {EXP_W{1'b0}}) ? EXP_ONE : {1'b0, in_exp};
                    sign_d  = in_sign;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CAPT: begin
                if (mant_q == MANT_ZERO) begin
                    state_d     = S_OUT;
                    out_valid_d = 1'b1;
                    result_d    = RES_ZERO;
                    ovf_d       = 1'b0;
                    unf_d       = 1'b0;
                    inx_d       = 1'b0;
                end else if (mant_q[WIDTH]) begin
                    // carry out of the adder: the dropped bit folds into sticky
                    mant_d  = {1'b0, mant_q[WIDTH:2], mant_q[1] | mant_q[0]};
                    exp_d   = exp_q + EXP_ONE;
                    state_d = S_ROUND;
                end else begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
`ifdef FPU_NORM_LZC_EN
                mant_d  = norm_mant_s;
                exp_d   = norm_exp_s;
                state_d = S_ROUND;
`else
                if (mant_q[WIDTH-1]) begin
                    state_d = S_ROUND;
                end else if (exp_q == EXP_ONE) begin
                    exp_d   = EXP_ZERO;
                    state_d = S_ROUND;
                end else begin
                    mant_d  = {mant_q[WIDTH-1:0], 1'b0};
                    exp_d   = exp_q - EXP_ONE;
                    state_d = S_NORM;
                end
`endif
            end
            S_ROUND: begin
                state_d     = S_OUT;
                out_valid_d = 1'b1;
                result_d    = rnd_result_s;
                ovf_d       = rnd_ovf_s;
                unf_d       = rnd_unf_s;
                inx_d       = rnd_inx_s;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // state and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mant_q      <= MANT_ZERO;
            exp_q       <= EXP_ZERO;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= RES_ZERO;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mant_q      <= mant_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            inx_q       <= inx_d;
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign out_valid     = out_valid_q;
    assign out_result    = result_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;
    assign out_inexact   = inx_q;

endmodule

// File: tb/tb_fpu_normalize_round.sv
// Directed, table-driven bench for fpu_normalize_round: results, flags, latency, backpressure and reset.
module tb_fpu_normalize_round;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [56:0] in_mant;
    logic        in_sign;
    logic [10:0] in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    int tests;
    int failed;

    typedef struct {
        logic [56:0] mant;
        logic        sign;
        logic [10:0] exp;
        logic [63:0] res;
        logic [2:0]  flg;   // {overflow, underflow, inexact}
        int          lat;   // bit-serial latency in edges after accept
    } vec_t;

    vec_t vecs[16];

    fpu_normalize_round dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mant       (in_mant),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        int lat_exp;
        lat_exp = v.lat;
`ifdef FPU_NORM_LZC_EN
        if (lat_exp > 3) lat_exp = 3;
`endif
        @(negedge clk);
        in_mant  = v.mant;
        in_sign  = v.sign;
        in_exp   = v.exp;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("v%0d latency", idx), 64'(n), 64'(lat_exp));
        check($sformatf("v%0d result", idx), out_result, v.res);
        check($sformatf("v%0d flags", idx), 64'({out_overflow, out_underflow, out_inexact}), 64'(v.flg));
        @(posedge clk);
        #1;
        check($sformatf("v%0d handshake", idx), 64'({out_valid, in_ready}), 64'(2'b01));
    endtask

    initial begin
        int n;
        tests = 0;
        failed = 0;
        vecs[0]  = '{(57'd1 << 56), 1'b0, 11'd1023, 64'h4000000000000000, 3'b000, 2};
        vecs[1]  = '{(57'd1 << 52), 1'b0, 11'd1023, 64'h3FC0000000000000, 3'b000, 6};
        vecs[2]  = '{(57'd1 << 55) | (57'd1 << 3) | (57'd1 << 2), 1'b0, 11'd1023, 64'h3FF0000000000002, 3'b001, 3};
        vecs[3]  = '{(57'd1 << 56) - (57'd1 << 3) + (57'd1 << 2), 1'b0, 11'd1023, 64'h4000000000000000, 3'b001, 3};
        vecs[4]  = '{(57'd1 << 56), 1'b0, 11'd2046, 64'h7FF0000000000000, 3'b101, 2};
        vecs[5]  = '{57'd0, 1'b1, 11'd1023, 64'h0000000000000000, 3'b000, 1};
        vecs[6]  = '{(57'd1 << 50), 1'b0, 11'd3, 64'h0002000000000000, 3'b000, 5};
        vecs[7]  = '{(57'd1 << 50) | 57'd1, 1'b0, 11'd3, 64'h0002000000000000, 3'b011, 5};
        vecs[8]  = '{(57'd1 << 55), 1'b1, 11'd1023, 64'hBFF0000000000000, 3'b000, 3};
        vecs[9]  = '{(57'd1 << 55), 1'b0, 11'd0, 64'h0010000000000000, 3'b000, 3};
        vecs[10] = '{(57'd1 << 55) - (57'd1 << 3) + (57'd1 << 2), 1'b0, 11'd1, 64'h0010000000000000, 3'b001, 3};
        vecs[11] = '{(57'd1 << 55) | (57'd1 << 2), 1'b0, 11'd1023, 64'h3FF0000000000000, 3'b001, 3};
        vecs[12] = '{(57'd1 << 56) | (57'd1 << 3) | 57'd1, 1'b0, 11'd1023, 64'h4000000000000001, 3'b001, 2};
        vecs[13] = '{(57'd1 << 56) - (57'd1 << 3) + (57'd1 << 2), 1'b1, 11'd2046, 64'hFFF0000000000000, 3'b101, 3};
        vecs[14] = '{(57'd1 << 54), 1'b0, 11'd2, 64'h0010000000000000, 3'b000, 4};
        vecs[15] = '{57'd1, 1'b0, 11'd1023, 64'h3C80000000000000, 3'b000, 58};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mant   = 57'd0;
        in_sign   = 1'b0;
        in_exp    = 11'd0;
        out_ready = 1'b1;
        #12;
        check("reset valid/ready", 64'({out_valid, in_ready}), 64'(2'b01));
        check("reset result", out_result, 64'h0);
        check("reset flags", 64'({out_overflow, out_underflow, out_inexact}), 64'(3'b000));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i], i);
        end

        // backpressure: result must hold while out_ready is low; busy-time in_valid is ignored
        out_ready = 1'b0;
        @(negedge clk);
        in_mant  = vecs[2].mant;
        in_sign  = vecs[2].sign;
        in_exp   = vecs[2].exp;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("hold busy ready", 64'(in_ready), 64'(1'b0));
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b1;
        in_mant  = 57'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold c%0d valid/ready", i), 64'({out_valid, in_ready}), 64'(2'b10));
            check($sformatf("hold c%0d result", i), out_result, 64'h3FF0000000000002);
            check($sformatf("hold c%0d flags", i), 64'({out_overflow, out_underflow, out_inexact}), 64'(3'b001));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold release", 64'({out_valid, in_ready}), 64'(2'b01));

        // reset while normalizing a long shift chain
        @(negedge clk);
        in_mant  = 57'd1;
        in_sign  = 1'b0;
        in_exp   = 11'd1023;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst valid/ready", 64'({out_valid, in_ready}), 64'(2'b01));
        check("midrst result", out_result, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[12], 100);
        run_vec(vecs[1], 101);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
